// File: rtl/ac_throttle_aggregator.sv
// ac_throttle_aggregator
// Merges NUM_SRC active-low board throttle sources into NUM_OUT active-low
// CPU throttle pins. Each source is double-flop synchronised, then
// glitch-filtered (FILTER_CYCLES consecutive differing samples to change).
// A static routing map plus a runtime mask select the sources that drive each
// output, and every output assertion is stretched to MIN_ASSERT_CYCLES.
// A sticky per-source event latch records filtered assertions.
//
// Optional feature: define AC_THROTTLE_EVENT_CNT_EN to add oEventCnt, one
// saturating 8-bit assertion counter per source.
//
// Handshake note: there is no valid/ready traffic here; iClrEvents is a
// single-cycle strobe, and every other input is a level.
module ac_throttle_aggregator #(
  parameter int NUM_SRC = 4,
  parameter int NUM_OUT = 2,
  parameter logic [NUM_OUT*NUM_SRC-1:0] ROUTE_MAP = {NUM_OUT*NUM_SRC{1'b1}},
  parameter int FILTER_CYCLES = 4,
  parameter int MIN_ASSERT_CYCLES = 16
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [NUM_SRC-1:0]   iSrc_n,
  input  logic [NUM_SRC-1:0]   iSrcMask,
  input  logic                 iClrEvents,
  output logic [NUM_OUT-1:0]   oThrottle_n,
  output logic [NUM_SRC-1:0]   oSrcFilt_n,
  output logic [NUM_SRC-1:0]   oEventLatch
`ifdef AC_THROTTLE_EVENT_CNT_EN
  ,
  output logic [NUM_SRC*8-1:0] oEventCnt
`endif
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int MW = $clog2(MIN_ASSERT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;
  logic [NUM_SRC-1:0] filt_n;
  logic [FW-1:0]      filt_cnt [NUM_SRC];
  logic [NUM_SRC-1:0] filt_flip;
  logic [NUM_SRC-1:0] filt_fall;
  logic [NUM_OUT-1:0] req;

  // Per-output stretch state, kept visible for hierarchical probing.
  state_t             stretch_state [NUM_OUT];
  logic [MW-1:0]      stretch_cnt   [NUM_OUT];

  assign oSrcFilt_n = filt_n;

  // Two-flop synchroniser; resets to the deasserted (high) level.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= iSrc_n;
      sync2 <= sync1;
    end
  end

  // Flip and falling-edge detection: the filter changes state on the
  // FILTER_CYCLES-th consecutive edge where synced and filtered disagree.
  always_comb begin
    filt_flip = '0;
    filt_fall = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      filt_flip[s] = (sync2[s] != filt_n[s]) &&
                     (filt_cnt[s] == FW'(FILTER_CYCLES - 1));
      filt_fall[s] = filt_flip[s] & filt_n[s];
    end
  end

  // Symmetric glitch filter: count disagreeing samples, clear on agreement.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      filt_n <= '1;
      for (int s = 0; s < NUM_SRC; s++) filt_cnt[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (sync2[s] != filt_n[s]) begin
          if (filt_flip[s]) begin
            filt_n[s]   <= ~filt_n[s];
            filt_cnt[s] <= '0;
          end else begin
            filt_cnt[s] <= filt_cnt[s] + FW'(1);
          end
        end else begin
          filt_cnt[s] <= '0;
        end
      end
    end
  end

  // Output request: any routed, unmasked, asserted filtered source.
  always_comb begin
    req = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        req[o] = req[o] | (ROUTE_MAP[o*NUM_SRC+s] & ~iSrcMask[s] & ~filt_n[s]);
      end
    end
  end

  // Stretch FSM per output: minimum-width ASSERT phase, then HOLD while
  // the request persists. The counter is loaded only on entry to ASSERT.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oThrottle_n <= '1;
      for (int o = 0; o < NUM_OUT; o++) begin
        stretch_state[o] <= ST_IDLE;
        stretch_cnt[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_OUT; o++) begin
        case (stretch_state[o])
          ST_IDLE: begin
            if (req[o]) begin
              stretch_state[o] <= ST_ASSERT;
              stretch_cnt[o]   <= MW'(MIN_ASSERT_CYCLES - 1);
              oThrottle_n[o]   <= 1'b0;
            end
          end
          ST_ASSERT: begin
            if (stretch_cnt[o] == '0) begin
              if (req[o]) begin
                stretch_state[o] <= ST_HOLD;
              end else begin
                stretch_state[o] <= ST_IDLE;
                oThrottle_n[o]   <= 1'b1;
              end
            end else begin
              stretch_cnt[o] <= stretch_cnt[o] - MW'(1);
            end
          end
          ST_HOLD: begin
            if (!req[o]) begin
              stretch_state[o] <= ST_IDLE;
              oThrottle_n[o]   <= 1'b1;
            end
          end
          default: begin
            stretch_state[o] <= ST_IDLE;
            oThrottle_n[o]   <= 1'b1;
          end
        endcase
      end
    end
  end

  // Sticky event latch; a new falling edge beats a simultaneous clear.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oEventLatch <= '0;
    end else begin
      oEventLatch <= (oEventLatch & ~{NUM_SRC{iClrEvents}}) | filt_fall;
    end
  end

`ifdef AC_THROTTLE_EVENT_CNT_EN
  logic [NUM_SRC-1:0][7:0] evt_cnt;

  assign oEventCnt = evt_cnt;

  // Saturating assertion counters; clear with a coincident event yields 1.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      evt_cnt <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (iClrEvents) begin
          evt_cnt[s] <= filt_fall[s] ? 8'd1 : 8'd0;
        end else if (filt_fall[s] && (evt_cnt[s] != 8'hFF)) begin
          evt_cnt[s] <= evt_cnt[s] + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ac_throttle_aggregator.sv
// Directed testbench for ac_throttle_aggregator. Two instances share the
// clock and reset: one with the default all-ones routing map, one with
// ROUTE_MAP = 8'b0011_1100 (out1 <- src0/src1, out0 <- src2/src3).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_ac_throttle_aggregator;

  logic       clk;
  logic       rst;
  logic [3:0] src_n;
  logic [3:0] mask;
  logic       clr;
  logic [1:0] thr_n;
  logic [3:0] filt_n;
  logic [3:0] latch;

  logic [3:0] r_src_n;
  logic [3:0] r_mask;
  logic       r_clr;
  logic [1:0] r_thr_n;
  logic [3:0] r_filt_n;
  logic [3:0] r_latch;

`ifdef AC_THROTTLE_EVENT_CNT_EN
  logic [31:0] evt_cnt;
  logic [31:0] r_evt_cnt;
`endif

  int n_cmp;
  int n_err;

  ac_throttle_aggregator dut (
    .iClk        (clk),
    .iRst        (rst),
    .iSrc_n      (src_n),
    .iSrcMask    (mask),
    .iClrEvents  (clr),
    .oThrottle_n (thr_n),
    .oSrcFilt_n  (filt_n),
    .oEventLatch (latch)
`ifdef AC_THROTTLE_EVENT_CNT_EN
    ,
    .oEventCnt   (evt_cnt)
`endif
  );

  ac_throttle_aggregator #(.ROUTE_MAP(8'b0011_1100)) dut_r (
    .iClk        (clk),
    .iRst        (rst),
    .iSrc_n      (r_src_n),
    .iSrcMask    (r_mask),
    .iClrEvents  (r_clr),
    .oThrottle_n (r_thr_n),
    .oSrcFilt_n  (r_filt_n),
    .oEventLatch (r_latch)
`ifdef AC_THROTTLE_EVENT_CNT_EN
    ,
    .oEventCnt   (r_evt_cnt)
`endif
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_n = 4'hF; mask = 4'h0; clr = 1'b0;
    r_src_n = 4'hF; r_mask = 4'h0; r_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    n_cmp++;
    if (thr_n !== 2'b11) begin
      n_err++; $display("FAIL reset_thr got=%b exp=%b", thr_n, 2'b11);
    end
    n_cmp++;
    if (latch !== 4'h0) begin
      n_err++; $display("FAIL reset_latch got=%b exp=%b", latch, 4'h0);
    end
    n_cmp++;
    if (filt_n !== 4'hF) begin
      n_err++; $display("FAIL reset_filt got=%b exp=%b", filt_n, 4'hF);
    end
  endtask

  task automatic test_glitch();
    src_n[0] = 1'b0;
    tick(3);
    src_n[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      n_cmp++;
      if (filt_n !== 4'hF || thr_n !== 2'b11) begin
        n_err++;
        $display("FAIL glitch k=%0d got filt=%b thr=%b exp filt=1111 thr=11", k, filt_n, thr_n);
      end
    end
    n_cmp++;
    if (latch !== 4'h0) begin
      n_err++; $display("FAIL glitch_latch got=%b exp=%b", latch, 4'h0);
    end
  endtask

  task automatic test_latency();
    logic [1:0] exp_thr;
    src_n[1] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp_thr = (k == 7) ? 2'b00 : 2'b11;
      n_cmp++;
      if (thr_n !== exp_thr) begin
        n_err++; $display("FAIL assert_lat k=%0d got=%b exp=%b", k, thr_n, exp_thr);
      end
      if (k == 5) begin
        n_cmp++;
        if (filt_n !== 4'b1111) begin
          n_err++; $display("FAIL filt_lead k=5 got=%b exp=1111", filt_n);
        end
      end
      if (k == 6) begin
        n_cmp++;
        if (filt_n !== 4'b1101) begin
          n_err++; $display("FAIL filt_lead k=6 got=%b exp=1101", filt_n);
        end
      end
    end
    tick(33);
    src_n[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp_thr = (k == 7) ? 2'b11 : 2'b00;
      n_cmp++;
      if (thr_n !== exp_thr) begin
        n_err++; $display("FAIL deassert_lat k=%0d got=%b exp=%b", k, thr_n, exp_thr);
      end
    end
    n_cmp++;
    if (latch !== 4'b0010) begin
      n_err++; $display("FAIL latency_latch got=%b exp=0010", latch);
    end
  endtask

  task automatic test_min_width();
    int first_low;
    int low_cnt;
    first_low = -1;
    low_cnt = 0;
    src_n[2] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (k == 5) src_n[2] = 1'b1;
      if (thr_n == 2'b00) begin
        low_cnt++;
        if (first_low < 0) first_low = k;
      end
    end
    n_cmp++;
    if (first_low !== 7) begin
      n_err++; $display("FAIL minw_first got=%0d exp=7", first_low);
    end
    n_cmp++;
    if (low_cnt !== 16) begin
      n_err++; $display("FAIL minw_width got=%0d exp=16", low_cnt);
    end
    n_cmp++;
    if (latch !== 4'b0110) begin
      n_err++; $display("FAIL minw_latch got=%b exp=0110", latch);
    end
  endtask

  task automatic test_clr_same_edge();
    src_n[3] = 1'b0;
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    n_cmp++;
    if (filt_n !== 4'b0111) begin
      n_err++; $display("FAIL clr_filt got=%b exp=0111", filt_n);
    end
    n_cmp++;
    if (latch !== 4'b1000) begin
      n_err++; $display("FAIL clr_latch got=%b exp=1000", latch);
    end
`ifdef AC_THROTTLE_EVENT_CNT_EN
    n_cmp++;
    if (evt_cnt !== 32'h01_00_00_00) begin
      n_err++; $display("FAIL clr_cnt got=%h exp=01000000", evt_cnt);
    end
`endif
    src_n[3] = 1'b1;
    tick(30);
  endtask

  task automatic test_route_mask();
    logic [1:0] exp_thr;
    r_src_n[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp_thr = (k == 7) ? 2'b01 : 2'b11;
      n_cmp++;
      if (r_thr_n !== exp_thr) begin
        n_err++; $display("FAIL route k=%0d got=%b exp=%b", k, r_thr_n, exp_thr);
      end
    end
    tick(20);
    n_cmp++;
    if (r_thr_n !== 2'b01) begin
      n_err++; $display("FAIL route_hold got=%b exp=01", r_thr_n);
    end
    r_mask[0] = 1'b1;
    tick(1);
    n_cmp++;
    if (r_thr_n !== 2'b11) begin
      n_err++; $display("FAIL mask_release got=%b exp=11", r_thr_n);
    end
    n_cmp++;
    if (r_latch[0] !== 1'b1) begin
      n_err++; $display("FAIL mask_latch got=%b exp=1", r_latch[0]);
    end
    r_src_n[0] = 1'b1;
    tick(12);
    r_mask = 4'h0;
    tick(2);
    n_cmp++;
    if (r_thr_n !== 2'b11) begin
      n_err++; $display("FAIL route_idle got=%b exp=11", r_thr_n);
    end
    // Masking the only source during ASSERT must not cut the minimum width.
    r_src_n[1] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      exp_thr = (k >= 7 && k <= 22) ? 2'b01 : 2'b11;
      n_cmp++;
      if (r_thr_n !== exp_thr) begin
        n_err++; $display("FAIL mask_in_assert k=%0d got=%b exp=%b", k, r_thr_n, exp_thr);
      end
      if (k == 9) r_mask[1] = 1'b1;
    end
    r_src_n[1] = 1'b1;
    tick(12);
    r_mask = 4'h0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_thr;
    src_n[2] = 1'b0;
    tick(7);
    n_cmp++;
    if (thr_n !== 2'b00) begin
      n_err++; $display("FAIL rmid_pre got=%b exp=00", thr_n);
    end
    tick(3);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (thr_n !== 2'b11 || filt_n !== 4'hF || latch !== 4'h0) begin
      n_err++;
      $display("FAIL rmid_async got thr=%b filt=%b latch=%b exp thr=11 filt=1111 latch=0000", thr_n, filt_n, latch);
    end
    tick(2);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp_thr = (k == 7) ? 2'b00 : 2'b11;
      n_cmp++;
      if (thr_n !== exp_thr) begin
        n_err++; $display("FAIL rmid_relat k=%0d got=%b exp=%b", k, thr_n, exp_thr);
      end
    end
    src_n[2] = 1'b1;
    tick(30);
  endtask

`ifdef AC_THROTTLE_EVENT_CNT_EN
  task automatic test_saturation();
    for (int p = 0; p < 300; p++) begin
      src_n[0] = 1'b0;
      tick(5);
      src_n[0] = 1'b1;
      tick(8);
      if (p == 199) begin
        n_cmp++;
        if (evt_cnt[7:0] !== 8'd200) begin
          n_err++; $display("FAIL sat_mid got=%0d exp=200", evt_cnt[7:0]);
        end
      end
    end
    n_cmp++;
    if (evt_cnt[7:0] !== 8'd255) begin
      n_err++; $display("FAIL sat_end got=%0d exp=255", evt_cnt[7:0]);
    end
    n_cmp++;
    if (latch[0] !== 1'b1) begin
      n_err++; $display("FAIL sat_latch got=%b exp=1", latch[0]);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_glitch();
    test_latency();
    test_min_width();
    test_clr_same_edge();
    test_route_mask();
    test_reset_mid();
`ifdef AC_THROTTLE_EVENT_CNT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ac_throttle_aggregator.md
# ac_throttle_aggregator

Parametrised throttle aggregator that drives NUM_OUT active-low throttle outputs (PROCHOT, MEMHOT and similar, per CPU) from NUM_SRC active-low throttle sources. Each source is synchronised and glitch-filtered. A per-output routing map and a runtime mask select which sources drive each output. Every output assertion is stretched to a minimum width. The block sits in the core CPLD between board VRHOT/PSYS/throttle pins and the CPU thermal pins, and replaces fixed combinational AND-ing.

## Interface
Parameters:
- NUM_SRC, 4: number of active-low throttle sources.
- NUM_OUT, 2: number of active-low throttle outputs.
- ROUTE_MAP, {NUM_OUT*NUM_SRC{1'b1}}: bit [o*NUM_SRC+s] = 1 routes source s to output o.
- FILTER_CYCLES, 4: consecutive differing samples needed to change a filtered source state. Legal range ≥1.
- MIN_ASSERT_CYCLES, 16: minimum output low time, in clocks. Legal range ≥1.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  asynchronous, active-high reset.
- iSrc_n  in  NUM_SRC  raw throttle sources, active low, asynchronous to iClk.
- iSrcMask  in  NUM_SRC  1 = source ignored for output generation. Synchronous to iClk.
- iClrEvents  in  1  single-cycle pulse that clears the event log.
- oThrottle_n  out  NUM_OUT  registered throttle outputs, active low.
- oSrcFilt_n  out  NUM_SRC  filtered source state, active low.
- oEventLatch  out  NUM_SRC  sticky flag per source: set when the filtered source has asserted since the last clear.
- oEventCnt  out  NUM_SRC*8  per-source assertion counters; present only with AC_THROTTLE_EVENT_CNT_EN.

## Operation
- Synchroniser: 2-flop per source. Reset value 1.
- Filter, per source: a counter of width $clog2(FILTER_CYCLES+1).
  - The counter increments on each edge where the synced value ≠ the filtered value, and clears to 0 on each edge where they are equal.
  - The filtered value flips on the FILTER_CYCLES-th consecutive differing edge; the counter clears on that same edge.
  - Filtering is symmetric for assertion and deassertion. Reset: filtered = 1, counter = 0.
- Request for output o: req[o] = OR over s of (ROUTE_MAP[o*NUM_SRC+s] & ~iSrcMask[s] & ~filt_n[s]).
- Stretch, per output: a state machine with states IDLE, ASSERT and HOLD.
  - IDLE (output 1): when req rises, go to ASSERT, drive output 0, and load the counter with MIN_ASSERT_CYCLES-1.
  - ASSERT: the counter decrements to 0. Request activity during ASSERT does not reload the counter. At counter = 0: if req = 1, go to HOLD; else go to IDLE and drive output 1.
  - HOLD: output stays 0 until req = 0, then go to IDLE and drive output 1 on the next edge.
  - A source masked while the output is in ASSERT does not shorten the minimum width.
- Event latch: set on the edge where a filtered source goes 1→0, regardless of mask. Cleared by iClrEvents. If set and clear happen on the same edge, set wins.
- Reset (asynchronous, at any time including mid-stretch):
  - oThrottle_n = all 1, oSrcFilt_n = all 1, oEventLatch = 0, oEventCnt = 0.
  - All state machines return to IDLE.

## Timing
- Assertion latency: a source going low and staying low gives oThrottle_n low on the (FILTER_CYCLES+3)-th rising edge after the first edge that samples it low. The breakdown is 2 sync + FILTER_CYCLES filter + 1 output register.
- Deassertion latency: the same FILTER_CYCLES+3 edges, lower-bounded by the stretch.
- oSrcFilt_n leads oThrottle_n by one edge.
- A glitch shorter than FILTER_CYCLES synced clocks never reaches any output.
- Minimum oThrottle_n low width: exactly MIN_ASSERT_CYCLES clocks when req lasts ≤ MIN_ASSERT_CYCLES.
- iSrcMask takes effect on req in the same cycle it is sampled, so output timing is 1 edge (subject to the stretch).

## Configuration
- AC_THROTTLE_EVENT_CNT_EN defined:
  - oEventCnt is present: one 8-bit counter per source.
  - The counter increments on each filtered 1→0 transition and saturates at 255.
  - iClrEvents clears it to 0. On a simultaneous increment and clear, the result is 1.
- Not defined: the oEventCnt port and its logic are omitted. All other behaviour is identical.

## Test plan
- Reset release with all sources high: oThrottle_n = 2'b11, oEventLatch = 0. With FILTER_CYCLES=4, drive iSrc_n[0] low for 3 clocks: no output change and no event.
- Defaults, iSrc_n[1] low for 40 clocks: oThrottle_n = 2'b00 on edge 7 after the sample, and stays low until 7 edges after release. oEventLatch[1] = 1.
- iSrc_n[2] low for 5 clocks (filters pass): oThrottle_n low for exactly 16 clocks.
- ROUTE_MAP = 8'b0011_1100 (out1 ← src0/src1, out0 ← src2/src3), iSrc_n[0] low: only oThrottle_n[1] asserts. Then set iSrcMask[0]=1 mid-HOLD: oThrottle_n[1] releases on the next edge; oEventLatch[0] stays 1.
- iClrEvents pulse on the same edge that src3's filtered value falls: oEventLatch[3] = 1. With the macro defined, oEventCnt[3] = 1. Drive 300 assertions: oEventCnt saturates at 255.
- Assert iRst mid-ASSERT: outputs go to 1 immediately, asynchronously. After release with the source still low, re-assertion takes the full FILTER_CYCLES+3 latency.
